// File: rtl/hazard_unit.sv
// Hazard unit: stall, flush and operand-forwarding control for the 5-stage core.
// Ports: clk/rst (async, active-high); RS1D/RS2D, RS1E/RS2E, RDE, RDM, RDW register ids;
//   ResultSrcE (01 = load), RegWriteM/W, PCSrcE (redirect in E), perf_clr;
//   outputs StallF, StallD, FlushD, FlushE, ForwardAE/BE (00 RD, 10 ALUResultM, 01 ResultW),
//   stall_count/flush_count (live only with HAZARD_PERF_EN defined, otherwise tied to 0).
module hazard_unit #(
    parameter int RESET_FLUSH_CYCLES = 4,
    parameter int COUNT_W            = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         RS1D,
    input  logic [4:0]         RS2D,
    input  logic [4:0]         RS1E,
    input  logic [4:0]         RS2E,
    input  logic [4:0]         RDE,
    input  logic [4:0]         RDM,
    input  logic [4:0]         RDW,
    input  logic [1:0]         ResultSrcE,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               PCSrcE,
    input  logic               perf_clr,
    output logic               StallF,
    output logic               StallD,
    output logic               FlushD,
    output logic               FlushE,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam int CNT_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_FLUSH_CYCLES - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_load_use;
    logic             w_run;

    // M beats W because it holds the younger write; x0 is never a forward source.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       wm,
        input logic [4:0] rdw,
        input logic       ww
    );
        if (wm && (rdm != 5'd0) && (rdm == rs))
            return 2'b10;
        else if (ww && (rdw != 5'd0) && (rdw == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(RS1E, RDM, RegWriteM, RDW, RegWriteW);
    assign w_fwd_b = fwd_sel(RS2E, RDM, RegWriteM, RDW, RegWriteW);

    assign w_load_use = (ResultSrcE == 2'b01) && (RDE != 5'd0) &&
                        ((RDE == RS1D) || (RDE == RS2D));

    assign w_run = (r_state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= CNT_LOAD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
        unique case (r_state)
            INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (r_cnt == '0)
                    w_state_nxt = RUN;
                else
                    w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            RUN: begin
                ForwardAE = w_fwd_a;
                ForwardBE = w_fwd_b;
                // A redirect squashes D, so a load-use on that instruction is moot.
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (w_load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [COUNT_W-1:0] r_stall_count;
    logic [COUNT_W-1:0] r_flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (perf_clr) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_run && w_load_use && !PCSrcE && (r_stall_count != '1))
                r_stall_count <= r_stall_count + COUNT_W'(1);
            if (w_run && PCSrcE && (r_flush_count != '1))
                r_flush_count <= r_flush_count + COUNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    logic w_unused_perf_clr;

    assign w_unused_perf_clr = perf_clr;
    assign stall_count       = '0;
    assign flush_count       = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected controls and counters are queued per step
// and compared on the falling edge, away from the rising edge where state changes.
module tb_hazard_unit;

    localparam int CW = 2;

    localparam logic [7:0] C_INIT  = 8'b1011_0000;
    localparam logic [7:0] C_STALL = 8'b1101_0000;
    localparam logic [7:0] C_REDIR = 8'b0011_0000;
    localparam logic [7:0] C_IDLE  = 8'b0000_0000;

    typedef struct {
        string      tag;
        logic [7:0] ctl;
        logic [1:0] sc;
        logic [1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, PCSrcE, perf_clr;
    logic          StallF, StallD, FlushD, FlushE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] stall_count, flush_count;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_unit #(
        .RESET_FLUSH_CYCLES(4),
        .COUNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .RS1D(RS1D),
        .RS2D(RS2D),
        .RS1E(RS1E),
        .RS2E(RS2E),
        .RDE(RDE),
        .RDM(RDM),
        .RDW(RDW),
        .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE),
        .perf_clr(perf_clr),
        .StallF(StallF),
        .StallD(StallD),
        .FlushD(FlushD),
        .FlushE(FlushE),
        .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    // Counters only exist in the perf build; otherwise they must read 0.
    function automatic logic [1:0] ec(input int v);
        logic [1:0] r;
`ifdef HAZARD_PERF_EN
        r = v[1:0];
`else
        r = 2'd0;
`endif
        return r;
    endfunction

    task automatic clear_inputs();
        RS1D = 0; RS2D = 0; RS1E = 0; RS2E = 0;
        RDE = 0; RDM = 0; RDW = 0;
        ResultSrcE = 2'b00;
        RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; perf_clr = 0;
    endtask

    task automatic step(input string tag, input logic [7:0] ctl,
                        input int sc, input int fc);
        exp_t e;
        exp_t g;
        logic [7:0] obs;
        logic [3:0] obs_c;
        e.tag = tag;
        e.ctl = ctl;
        e.sc  = ec(sc);
        e.fc  = ec(fc);
        q.push_back(e);
        @(negedge clk);
        g     = q.pop_front();
        obs   = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
        obs_c = {stall_count, flush_count};
        n_tests++;
        assert (obs === g.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%b expected=%b", g.tag, obs, g.ctl);
        end
        n_tests++;
        assert (obs_c === {g.sc, g.fc}) else begin
            n_fail++;
            $error("FAIL %s counters observed=%b expected=%b", g.tag, obs_c, {g.sc, g.fc});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        step("rst_hold", C_INIT, 0, 0);
        rst = 1'b0;
        step("init0", C_INIT, 0, 0);
        step("init1", C_INIT, 0, 0);
        step("init2", C_INIT, 0, 0);
        step("init3", C_INIT, 0, 0);
        step("run0", C_IDLE, 0, 0);

        RS1E = 5; RDM = 5; RegWriteM = 1; RDW = 5; RegWriteW = 1;
        step("fwd_m_prio", 8'b0000_1000, 0, 0);
        RegWriteM = 0;
        step("fwd_w", 8'b0000_0100, 0, 0);
        RS2E = 0; RDM = 0; RegWriteM = 1; RDW = 0;
        step("fwd_x0_m", C_IDLE, 0, 0);
        RS1E = 9; RS2E = 9; RDM = 9; RegWriteM = 0; RDW = 9; RegWriteW = 1;
        step("fwd_w_ab", 8'b0000_0101, 0, 0);
        RS1E = 3; RS2E = 9; RDM = 9; RegWriteM = 1; RDW = 3;
        step("fwd_mixed", 8'b0000_0110, 0, 0);
        RS1E = 0; RS2E = 0; RDW = 0; RDM = 0;
        step("fwd_x0_w", C_IDLE, 0, 0);

        clear_inputs();
        ResultSrcE = 2'b01; RDE = 7; RS2D = 7;
        step("load_use", C_STALL, 0, 0);
        ResultSrcE = 2'b00; RDE = 0; RS2D = 0;
        step("bubble_done", C_IDLE, 1, 0);
        ResultSrcE = 2'b10; RDE = 7; RS1D = 7;
        step("not_load", C_IDLE, 1, 0);
        ResultSrcE = 2'b01; RDE = 0; RS1D = 0;
        step("load_x0", C_IDLE, 1, 0);
        RDE = 7; RS1D = 7; PCSrcE = 1;
        step("redir_wins", C_REDIR, 1, 0);
        clear_inputs();
        step("after_redir", C_IDLE, 1, 1);

        ResultSrcE = 2'b01; RDE = 4; RS1D = 4;
        step("pre_rst_stall", C_STALL, 1, 1);
        rst = 1'b1;
        step("async_rst", C_INIT, 0, 0);
        rst = 1'b0;
        clear_inputs();
        PCSrcE = 1;
        ResultSrcE = 2'b01; RDE = 4; RS1D = 4;
        step("reinit0", C_INIT, 0, 0);
        step("reinit1", C_INIT, 0, 0);
        step("reinit2", C_INIT, 0, 0);
        step("reinit3", C_INIT, 0, 0);
        clear_inputs();
        step("rerun", C_IDLE, 0, 0);

        ResultSrcE = 2'b01; RDE = 12; RS1D = 12;
        step("sat0", C_STALL, 0, 0);
        step("sat1", C_STALL, 1, 0);
        step("sat2", C_STALL, 2, 0);
        step("sat3", C_STALL, 3, 0);
        step("sat4", C_STALL, 3, 0);
        perf_clr = 1;
        step("clr_vs_inc", C_STALL, 3, 0);
        perf_clr = 0;
        clear_inputs();
        step("cleared", C_IDLE, 0, 0);
        step("stays_clear", C_IDLE, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
